// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO master.
//   state_t      - frame sequencer states
//   ST_* / OP_*  - start-of-frame and opcode field values (Clause 22 and 45)
//   *_W          - frame field widths, FRAME_W is the serialised body after the preamble
//   is_read_op   - decides whether a request turns the bus around for a read
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_STOP,
      S_ADDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] ST_C45 = 2'b00;

   localparam logic [1:0] OP_C22_WRITE    = 2'b01;
   localparam logic [1:0] OP_C22_READ     = 2'b10;
   localparam logic [1:0] OP_C45_ADDR     = 2'b00;
   localparam logic [1:0] OP_C45_WRITE    = 2'b01;
   localparam logic [1:0] OP_C45_READ_INC = 2'b10;
   localparam logic [1:0] OP_C45_READ     = 2'b11;

   // Turnaround pattern the master drives on writes.
   localparam logic [1:0] TA_DRIVE = 2'b10;

   localparam int ST_W    = 2;
   localparam int OP_W    = 2;
   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int TA_W    = 2;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = OP_W + PHYAD_W + REGAD_W;
   localparam int FRAME_W = ST_W + ADDR_W + TA_W + DATA_W;

   function automatic logic is_read_op(input logic cl45, input logic [OP_W-1:0] op);
      if (cl45) return (op == OP_C45_READ) || (op == OP_C45_READ_INC);
      return op == OP_C22_READ;
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// mdio_clkgen: MDC generator for the MDIO master.
//   clk, reset - system clock, async active-high reset
//   i_en       - run while the master is busy; when low, mdc is parked low
//   o_mdc      - management clock, CLK_DIV cycles low then CLK_DIV cycles high
//   o_rise     - one-cycle strobe in the last low cycle (mdc rises at that edge)
//   o_fall     - one-cycle strobe in the last high cycle (mdc falls at that edge)
module mdio_clkgen #(
   parameter int CLK_DIV = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_mdc,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [7:0] LOAD = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;
   logic       r_mdc;
   logic       w_tc;

   // Phase timer: a zero count marks the first cycle of a phase and reloads,
   // so a phase spans 0, CLK_DIV-1 .. 1 and ends on count 1.
   assign w_tc = i_en && (r_cnt == 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_mdc <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_mdc <= 1'b0;
      end else if (w_tc) begin
         r_cnt <= '0;
         r_mdc <= ~r_mdc;
      end else if (r_cnt == '0) begin
         r_cnt <= LOAD;
      end else begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign o_mdc  = r_mdc;
   assign o_rise = w_tc && !r_mdc;
   assign o_fall = w_tc && r_mdc;

endmodule

// File: rtl/mdio_master.sv
// mdio_master: MDIO (IEEE 802.3 Clause 22, optional Clause 45) bus master.
//   clk, reset                     - system clock, async active-high reset
//   t_valid/t_ready                - request handshake, ready only in IDLE
//   t_op, t_cl45, t_phyad,
//   t_regad, t_wdata               - request fields, captured on acceptance
//   rd_data, rd_valid, rd_err      - read completion; data/err hold until the next read
//   busy                           - high whenever a frame is in progress
//   mdc, mdio_out, mdio_oe, mdio_in- pad side; tristate buffer lives outside
// Build option: define MDIO_CL45_EN to honour t_cl45 (ST=00 Clause 45 frames).
//
// state  | meaning
// IDLE   | waiting for a request, bus released
// PRE    | preamble ones (skipped when PRE_LEN=0)
// STOP   | start-of-frame field
// ADDR   | opcode, port/PHY address, register/device address
// TA     | turnaround; reads release the line here
// DATA   | 16 data bits, driven on writes, sampled on reads
// DONE   | one cycle: publish read result, then back to IDLE
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int PRE_LEN = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               t_valid,
   output logic               t_ready,
   input  logic [OP_W-1:0]    t_op,
   input  logic               t_cl45,
   input  logic [PHYAD_W-1:0] t_phyad,
   input  logic [REGAD_W-1:0] t_regad,
   input  logic [DATA_W-1:0]  t_wdata,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   output logic               rd_err,
   output logic               busy,
   output logic               mdc,
   output logic               mdio_out,
   output logic               mdio_oe,
   input  logic               mdio_in
);

   localparam logic [5:0] PRE_LEN_M1 = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

   state_t              r_state, w_state_nx;
   logic [5:0]          r_bits, w_bits_nx;
   logic [FRAME_W-1:0]  r_sr, w_sr_nx;
   logic [DATA_W-1:0]   r_rx, w_rx_nx;
   logic [DATA_W-1:0]   r_rd_data, w_rd_data_nx;
   logic                r_is_read, w_is_read_nx;
   logic                r_mdio_out, w_mdio_out_nx;
   logic                r_mdio_oe, w_mdio_oe_nx;
   logic                r_rd_valid, w_rd_valid_nx;
   logic                r_rd_err, w_rd_err_nx;
   logic                w_busy, w_rise, w_fall, w_cl45, w_req_read;
   logic [ST_W-1:0]     w_st;
   logic [FRAME_W-1:0]  w_frame;

`ifdef MDIO_CL45_EN
   assign w_cl45 = t_cl45;
`else
   logic w_unused_cl45;
   assign w_unused_cl45 = t_cl45;
   assign w_cl45        = 1'b0;
`endif

   assign w_st       = w_cl45 ? ST_C45 : ST_C22;
   assign w_req_read = is_read_op(w_cl45, t_op);
   // Reads carry the same body; TA and data are never driven because oe drops.
   assign w_frame    = {w_st, t_op, t_phyad, t_regad, TA_DRIVE, t_wdata};

   assign w_busy = (r_state != S_IDLE);

   mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_busy),
      .o_mdc  (mdc),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_bits     <= '0;
         r_sr       <= '0;
         r_rx       <= '0;
         r_is_read  <= 1'b0;
         r_mdio_out <= 1'b1;
         r_mdio_oe  <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_bits     <= w_bits_nx;
         r_sr       <= w_sr_nx;
         r_rx       <= w_rx_nx;
         r_is_read  <= w_is_read_nx;
         r_mdio_out <= w_mdio_out_nx;
         r_mdio_oe  <= w_mdio_oe_nx;
         r_rd_data  <= w_rd_data_nx;
         r_rd_valid <= w_rd_valid_nx;
         r_rd_err   <= w_rd_err_nx;
      end
   end

   // r_bits counts the bits still to go in the current field; a fall strobe
   // with r_bits==0 ends the field. Acceptance acts as the first bit start.
   always_comb begin
      w_state_nx    = r_state;
      w_bits_nx     = r_bits;
      w_sr_nx       = r_sr;
      w_rx_nx       = r_rx;
      w_is_read_nx  = r_is_read;
      w_mdio_out_nx = r_mdio_out;
      w_mdio_oe_nx  = r_mdio_oe;
      w_rd_data_nx  = r_rd_data;
      w_rd_valid_nx = 1'b0;
      w_rd_err_nx   = r_rd_err;
      case (r_state)
         S_IDLE: begin
            w_mdio_out_nx = 1'b1;
            w_mdio_oe_nx  = 1'b0;
            if (t_valid) begin
               w_is_read_nx = w_req_read;
               w_mdio_oe_nx = 1'b1;
               if (w_req_read) w_rd_err_nx = 1'b0;
               if (PRE_LEN > 0) begin
                  w_state_nx = S_PRE;
                  w_bits_nx  = PRE_LEN_M1;
                  w_sr_nx    = w_frame;
               end else begin
                  w_state_nx    = S_STOP;
                  w_bits_nx     = 6'(ST_W - 1);
                  w_mdio_out_nx = w_frame[FRAME_W-1];
                  w_sr_nx       = {w_frame[FRAME_W-2:0], 1'b0};
               end
            end
         end
         S_DONE: begin
            w_state_nx    = S_IDLE;
            w_mdio_out_nx = 1'b1;
            w_mdio_oe_nx  = 1'b0;
         end
         default: begin
            if (w_rise && r_is_read) begin
               if (r_state == S_TA && r_bits == '0 && mdio_in) w_rd_err_nx = 1'b1;
               if (r_state == S_DATA) w_rx_nx = {r_rx[DATA_W-2:0], mdio_in};
            end
            if (w_fall) begin
               if (r_bits != '0) begin
                  w_bits_nx = r_bits - 6'd1;
                  if (r_state != S_PRE) begin
                     w_mdio_out_nx = r_sr[FRAME_W-1];
                     w_sr_nx       = {r_sr[FRAME_W-2:0], 1'b0};
                  end
               end else begin
                  case (r_state)
                     S_PRE: begin
                        w_state_nx = S_STOP;
                        w_bits_nx  = 6'(ST_W - 1);
                     end
                     S_STOP: begin
                        w_state_nx = S_ADDR;
                        w_bits_nx  = 6'(ADDR_W - 1);
                     end
                     S_ADDR: begin
                        w_state_nx = S_TA;
                        w_bits_nx  = 6'(TA_W - 1);
                        if (r_is_read) w_mdio_oe_nx = 1'b0;
                     end
                     S_TA: begin
                        w_state_nx = S_DATA;
                        w_bits_nx  = 6'(DATA_W - 1);
                     end
                     default: begin
                        w_state_nx = S_DONE;
                        w_bits_nx  = '0;
                     end
                  endcase
                  if (r_state == S_DATA) begin
                     w_mdio_out_nx = 1'b1;
                     w_mdio_oe_nx  = 1'b0;
                     if (r_is_read) begin
                        w_rd_valid_nx = 1'b1;
                        w_rd_data_nx  = r_rx;
                     end
                  end else begin
                     w_mdio_out_nx = r_sr[FRAME_W-1];
                     w_sr_nx       = {r_sr[FRAME_W-2:0], 1'b0};
                  end
               end
            end
         end
      endcase
   end

   assign t_ready  = (r_state == S_IDLE);
   assign busy     = w_busy;
   assign mdio_out = r_mdio_out;
   assign mdio_oe  = r_mdio_oe;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_mdio_master.sv
`timescale 1ns/1ps
module tb_mdio_master;
   import mdio_pkg::*;

   localparam int CD0 = 4, PL0 = 32;
   localparam int CD1 = 2, PL1 = 0;
`ifdef MDIO_CL45_EN
   localparam bit CL45_BUILD = 1'b1;
`else
   localparam bit CL45_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, t_valid, t_ready, t_cl45, rd_valid, rd_err, busy;
   logic [1:0]       mdc, mdio_out, mdio_oe, mdio_in;
   logic [1:0][1:0]  t_op;
   logic [1:0][4:0]  t_phyad, t_regad;
   logic [1:0][15:0] t_wdata, rd_data;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] m_data [2];
   logic        m_err  [2];

   mdio_master #(.CLK_DIV(CD0), .PRE_LEN(PL0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .t_valid(t_valid[0]), .t_ready(t_ready[0]),
      .t_op(t_op[0]), .t_cl45(t_cl45[0]), .t_phyad(t_phyad[0]), .t_regad(t_regad[0]),
      .t_wdata(t_wdata[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_err(rd_err[0]),
      .busy(busy[0]), .mdc(mdc[0]), .mdio_out(mdio_out[0]), .mdio_oe(mdio_oe[0]),
      .mdio_in(mdio_in[0]));

   mdio_master #(.CLK_DIV(CD1), .PRE_LEN(PL1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .t_valid(t_valid[1]), .t_ready(t_ready[1]),
      .t_op(t_op[1]), .t_cl45(t_cl45[1]), .t_phyad(t_phyad[1]), .t_regad(t_regad[1]),
      .t_wdata(t_wdata[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_err(rd_err[1]),
      .busy(busy[1]), .mdc(mdc[1]), .mdio_out(mdio_out[1]), .mdio_oe(mdio_oe[1]),
      .mdio_in(mdio_in[1]));

   function automatic logic model_read(input logic cl45, input logic [1:0] op);
      if (cl45 && CL45_BUILD) return (op == 2'b11) || (op == 2'b10);
      return op == 2'b10;
   endfunction

   // PHY model: bit k of an nb-bit frame as seen on mdio_in (pull-up when undriven).
   function automatic logic phy_bit(input int k, input int nb, input logic rd,
                                    input logic present, input logic [15:0] pdata);
      if (!rd || !present) return 1'b1;
      if (k == nb - 17) return 1'b0;
      if (k >= nb - 16 && k < nb) return pdata[nb - 1 - k];
      return 1'b1;
   endfunction

   task automatic run_frame(input int idx, input logic cl45, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                            input logic present, input logic [15:0] pdata, input logic hold,
                            input string name, output logic [63:0] got_line);
      int cd, pl, nb, busy_cyc, hi_cyc, rises, rdv;
      logic rd, prev_mdc, ready_bad;
      logic [1:0] st;
      logic [63:0] eline, emask, gline, goe;
      logic [15:0] got_data;
      cd = (idx == 0) ? CD0 : CD1;
      pl = (idx == 0) ? PL0 : PL1;
      nb = pl + 32;
      rd = model_read(cl45, op);
      st = (cl45 && CL45_BUILD) ? 2'b00 : 2'b01;
      eline = '0;
      for (int i = 0; i < pl; i++) eline = {eline[62:0], 1'b1};
      eline = {eline[31:0], st, op, phy, rg, 2'b10, wd};
      emask = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
      if (rd) emask = emask & ~64'h3FFFF;
      if (rd) begin
         m_err[idx] = !present;
         m_data[idx] = present ? pdata : 16'hFFFF;
      end

      @(negedge clk);
      n_cmp++;
      if (t_ready[idx] !== 1'b1) begin
         n_bad++; $display("FAIL %s ready_before got %b want 1", name, t_ready[idx]);
      end
      t_cl45[idx] = cl45; t_op[idx] = op; t_phyad[idx] = phy; t_regad[idx] = rg;
      t_wdata[idx] = wd; mdio_in[idx] = phy_bit(0, nb, rd, present, pdata);
      t_valid[idx] = 1'b1;
      @(posedge clk); #1;
      if (!hold) t_valid[idx] = 1'b0;
      busy_cyc = 0; hi_cyc = 0; rises = 0; rdv = 0; prev_mdc = 1'b0; ready_bad = 1'b0;
      gline = '0; goe = '0; got_data = '0;
      for (int cyc = 0; cyc < 4000 && busy[idx] === 1'b1; cyc++) begin
         busy_cyc++;
         if (t_ready[idx] !== 1'b0) ready_bad = 1'b1;
         if (mdc[idx]) hi_cyc++;
         if (mdc[idx] && !prev_mdc) begin
            gline = {gline[62:0], mdio_out[idx]};
            goe   = {goe[62:0], mdio_oe[idx]};
            rises++;
            mdio_in[idx] = phy_bit(rises, nb, rd, present, pdata);
         end
         if (rd_valid[idx]) begin rdv++; got_data = rd_data[idx]; end
         prev_mdc = mdc[idx];
         @(posedge clk); #1;
      end
      t_valid[idx] = 1'b0;
      got_line = gline;

      n_cmp++;
      if (busy[idx] !== 1'b0) begin
         n_bad++; $display("FAIL %s timeout busy still %b", name, busy[idx]);
      end
      n_cmp++;
      if (rises != nb) begin
         n_bad++; $display("FAIL %s bit_count got %0d want %0d", name, rises, nb);
      end
      n_cmp++;
      if ((gline & emask) !== (eline & emask)) begin
         n_bad++; $display("FAIL %s line got %h want %h mask %h", name, gline, eline, emask);
      end
      n_cmp++;
      if (goe !== emask) begin
         n_bad++; $display("FAIL %s oe got %h want %h", name, goe, emask);
      end
      // one extra busy cycle for the completion state
      n_cmp++;
      if (busy_cyc != 2 * cd * nb + 1) begin
         n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cyc, 2 * cd * nb + 1);
      end
      n_cmp++;
      if (hi_cyc != cd * nb) begin
         n_bad++; $display("FAIL %s mdc_high got %0d want %0d", name, hi_cyc, cd * nb);
      end
      n_cmp++;
      if (rdv != (rd ? 1 : 0)) begin
         n_bad++; $display("FAIL %s rd_valid_pulses got %0d want %0d", name, rdv, rd ? 1 : 0);
      end
      n_cmp++;
      if (ready_bad !== 1'b0) begin
         n_bad++; $display("FAIL %s ready_while_busy got 1 want 0", name);
      end
      if (rd && rdv == 1) begin
         n_cmp++;
         if (got_data !== m_data[idx]) begin
            n_bad++; $display("FAIL %s rd_data_at_valid got %h want %h", name, got_data, m_data[idx]);
         end
      end
      n_cmp++;
      if (rd_data[idx] !== m_data[idx]) begin
         n_bad++; $display("FAIL %s rd_data got %h want %h", name, rd_data[idx], m_data[idx]);
      end
      n_cmp++;
      if (rd_err[idx] !== m_err[idx]) begin
         n_bad++; $display("FAIL %s rd_err got %b want %b", name, rd_err[idx], m_err[idx]);
      end
      n_cmp++;
      if ({mdc[idx], mdio_oe[idx], mdio_out[idx], t_ready[idx]} !== 4'b0011) begin
         n_bad++; $display("FAIL %s idle_pins got %b want 0011", name,
                           {mdc[idx], mdio_oe[idx], mdio_out[idx], t_ready[idx]});
      end
   endtask

   task automatic test_reset;
      rst = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({mdc[i], mdio_oe[i], mdio_out[i], rd_valid[i], rd_err[i], busy[i], t_ready[i]} !== 7'b0010001) begin
            n_bad++; $display("FAIL reset_pins[%0d] got %b want 0010001", i,
                              {mdc[i], mdio_oe[i], mdio_out[i], rd_valid[i], rd_err[i], busy[i], t_ready[i]});
         end
         n_cmp++;
         if (rd_data[i] !== 16'h0000) begin
            n_bad++; $display("FAIL reset_rd_data[%0d] got %h want 0000", i, rd_data[i]);
         end
         m_data[i] = 16'h0000;
         m_err[i]  = 1'b0;
      end
      #2 rst = 2'b00;
   endtask

   task automatic test_write_example;
      logic [63:0] line;
      run_frame(0, 1'b0, OP_C22_WRITE, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0, 1'b0, "write_1140", line);
      n_cmp++;
      if (line !== 64'hFFFF_FFFF_5082_1140) begin
         n_bad++; $display("FAIL write_1140_literal got %h want ffffffff50821140", line);
      end
   endtask

   task automatic test_read_phy;
      logic [63:0] line;
      run_frame(0, 1'b0, OP_C22_READ, 5'h01, 5'h01, 16'h0000, 1'b1, 16'h796D, 1'b0, "read_796d", line);
   endtask

   task automatic test_read_nophy;
      logic [63:0] line;
      run_frame(0, 1'b0, OP_C22_READ, 5'h02, 5'h05, 16'h0000, 1'b0, 16'h0, 1'b0, "read_nophy", line);
   endtask

   task automatic test_short_frame_held_valid;
      logic [63:0] line;
      run_frame(1, 1'b0, OP_C22_WRITE, 5'h1F, 5'h0A, 16'hA5C3, 1'b1, 16'h0, 1'b1, "short_held", line);
      run_frame(1, 1'b0, OP_C22_READ, 5'h11, 5'h02, 16'h0, 1'b1, 16'h1234, 1'b1, "short_read", line);
   endtask

   task automatic test_reset_midframe;
      logic [63:0] line;
      int rises, rdv;
      logic prev_mdc;
      @(negedge clk);
      t_cl45[0] = 1'b0; t_op[0] = OP_C22_READ; t_phyad[0] = 5'h01; t_regad[0] = 5'h03;
      t_wdata[0] = 16'h0; mdio_in[0] = 1'b1; t_valid[0] = 1'b1;
      @(posedge clk); #1;
      t_valid[0] = 1'b0;
      rises = 0; rdv = 0; prev_mdc = 1'b0;
      for (int cyc = 0; cyc < 2000 && rises < 41; cyc++) begin
         if (mdc[0] && !prev_mdc) rises++;
         if (rd_valid[0]) rdv++;
         prev_mdc = mdc[0];
         if (rises < 41) begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (rises != 41 || mdio_oe[0] !== 1'b1 || mdc[0] !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid_reach got rises=%0d oe=%b mdc=%b want 41 1 1", rises, mdio_oe[0], mdc[0]);
      end
      #2 rst[0] = 1'b1;
      #1;
      n_cmp++;
      if ({mdc[0], mdio_oe[0], busy[0], t_ready[0], rd_valid[0]} !== 5'b00010 || rdv != 0) begin
         n_bad++; $display("FAIL reset_mid_abort got %b rdv=%0d want 00010 rdv=0",
                           {mdc[0], mdio_oe[0], busy[0], t_ready[0], rd_valid[0]}, rdv);
      end
      m_data[0] = 16'h0000;
      m_err[0]  = 1'b0;
      @(posedge clk); #3;
      rst[0] = 1'b0;
      run_frame(0, 1'b0, OP_C22_WRITE, 5'h04, 5'h1C, 16'hBEEF, 1'b1, 16'h0, 1'b0, "after_reset", line);
   endtask

`ifdef MDIO_CL45_EN
   task automatic test_cl45_address;
      logic [63:0] line;
      run_frame(0, 1'b1, OP_C45_ADDR, 5'h03, 5'h01, 16'h0007, 1'b1, 16'h0, 1'b0, "cl45_addr", line);
      n_cmp++;
      if (line[31:0] !== {2'b00, 2'b00, 5'h03, 5'h01, 2'b10, 16'h0007}) begin
         n_bad++; $display("FAIL cl45_addr_literal got %h", line[31:0]);
      end
      run_frame(1, 1'b1, OP_C45_WRITE, 5'h03, 5'h01, 16'h55AA, 1'b1, 16'h0, 1'b0, "cl45_write", line);
      run_frame(1, 1'b1, OP_C45_READ, 5'h03, 5'h01, 16'h0, 1'b1, 16'hC0DE, 1'b0, "cl45_read", line);
   endtask
`endif

   task automatic test_random;
      logic [63:0] line;
      int idx;
      for (int n = 0; n < 24; n++) begin
         idx = $urandom_range(0, 1);
         run_frame(idx, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                   1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), "random", line);
      end
   endtask

   initial begin
      rst = 2'b11; t_valid = '0; t_cl45 = '0; t_op = '0; t_phyad = '0; t_regad = '0;
      t_wdata = '0; mdio_in = 2'b11;
      test_reset();
      test_write_example();
      test_read_phy();
      test_read_nophy();
      test_short_frame_held_valid();
      test_reset_midframe();
`ifdef MDIO_CL45_EN
      test_cl45_address();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per MDC half-period; legal values 2..255.
REQ-002 SHALL have parameter PRE_LEN, default 32: preamble length in bits; legal values 0..32, where 0 suppresses the preamble.
REQ-003 SHALL have port clk, input, width 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have ports t_valid in 1, t_ready out 1: request handshake.
REQ-006 SHALL have ports t_op in 2, t_cl45 in 1, t_phyad in 5, t_regad in 5, t_wdata in 16: request fields.
REQ-007 SHALL have ports rd_data out 16, rd_valid out 1, rd_err out 1, busy out 1: completion outputs.
REQ-008 SHALL have ports mdc out 1, mdio_out out 1, mdio_oe out 1, mdio_in in 1: pad-side signals; the tristate buffer is external.

Function
REQ-009 SHALL accept a request when t_valid && t_ready; t_ready SHALL be 1 only in IDLE; all request fields SHALL be latched on acceptance.
REQ-010 SHALL implement states IDLE -> PRE -> STOP -> ADDR -> TA -> DATA -> DONE -> IDLE; PRE SHALL be skipped when PRE_LEN=0.
REQ-011 SHALL form each bit as CLK_DIV cycles with mdc=0 followed by CLK_DIV cycles with mdc=1; the period is 2*CLK_DIV cycles.
REQ-012 SHALL update mdio_out/mdio_oe in the cycle mdc falls (bit start) and SHALL sample mdio_in in the cycle mdc rises.
REQ-013 SHALL send each frame MSB-first as: PRE_LEN ones, ST(2), OP(2), PHYAD(5), REGAD(5), TA(2), DATA(16).
REQ-014 Clause 22: ST=01; t_op 10=read, 01=write; t_op 00/11 SHALL be accepted and sent verbatim.
REQ-015 Write: SHALL drive TA=10 and t_wdata, with mdio_oe=1 for the whole frame.
REQ-016 Read: SHALL set mdio_oe=0 from the first TA bit through the last DATA bit; second TA bit sampled as 1 SHALL set rd_err=1.
REQ-017 SHALL enter DONE after the high phase of the final DATA bit; in DONE, rd_valid SHALL pulse for 1 cycle (read ops only), rd_data is updated, and the state returns to IDLE on the next cycle.
REQ-018 busy SHALL be 1 in every state except IDLE; in IDLE mdc=0, mdio_oe=0, mdio_out=1.
REQ-019 rd_data and rd_err SHALL hold until the next read completes; rd_err SHALL clear on acceptance of any read.
REQ-020 SHALL ignore t_valid while busy; no queueing.

Reset
REQ-021 SHALL force on reset, asynchronously: state=IDLE, mdc=0, mdio_oe=0, mdio_out=1, rd_data=0, rd_valid=0, rd_err=0, busy=0, t_ready=1, all counters 0.
REQ-022 Reset mid-frame SHALL abort the frame immediately, with no rd_valid; the first cycle after release SHALL accept a new request.

Configuration
REQ-023 With macro MDIO_CL45_EN defined, t_cl45=1 SHALL send ST=00 with t_op 00=address, 01=write, 11=read, 10=read-increment, and the 16-bit field SHALL carry t_wdata for address/write; t_phyad is the port address and t_regad is the device type.
REQ-024 Without MDIO_CL45_EN, t_cl45 SHALL be ignored and ST SHALL be 01 always.

Structure
REQ-025 Package mdio_pkg SHALL hold the state enum, ST constants (ST_C22=01, ST_C45=00), op codes and frame field widths.
REQ-026 Sub-module mdio_clkgen SHALL generate mdc plus one-cycle fall/rise strobes from CLK_DIV; it is enabled only while busy.

Verification
REQ-027 Write, CLK_DIV=4, PRE_LEN=32, phyad=01, regad=00, wdata=1140 -> 64 mdc periods (512 clk); serial pattern 32x1, 0101, 00001, 00000, 10, 0001000101000000; rd_valid never asserts.
REQ-028 Read, PHY model returns TA=z0 and data=796D -> mdio_oe=0 for the last 18 bits, rd_valid pulse with rd_data=796D, rd_err=0.
REQ-029 Read with no PHY (mdio_in pulled 1) -> rd_err=1, rd_data=FFFF.
REQ-030 PRE_LEN=0, CLK_DIV=2 -> frame of 32 bits totalling 128 clk; t_valid held high during busy does not start a second frame early.
REQ-031 Assert reset at bit 40 of a read -> mdc=0 and mdio_oe=0 in the same cycle, no rd_valid; a write accepted on the first cycle after release completes correctly.
REQ-032 With MDIO_CL45_EN: address frame, t_cl45=1, t_op=00, phyad=03, regad=01, wdata=0007 -> ST bits 00, OP 00, data 0007 on the line.
